jiajian_disp: RTL and testbench
===============================

# jiajian_disp

Result decoder and display driver for the 6-bit add/subtract unit. It captures the unit's 7-bit result `c` together with the operation select `sl` on a `start` pulse. It then converts the value to sign plus three BCD digits with a sequential double-dabble (shift-add-3) engine and drives four static seven-segment digit patterns. It is the consumer end of the adder's result interface, sitting between the arithmetic unit and the board display.

## Interface
- Parameters: none; all widths are fixed by the adder interface.
- `clk` — in, 1 — sole clock; rising-edge.
- `rst_n` — in, 1 — reset, asynchronous and active-low.
- `c` — in, 7 — adder result; sampled only when `start` is accepted.
- `sl` — in, 2 — operation select that produced `c`:
  - `00` = add (unsigned).
  - `11` = subtract (two's complement).
  - `01`/`10` = illegal.
- `start` — in, 1 — request conversion; honoured only in IDLE.
- `busy` — out, 1 — conversion in progress.
- `done` — out, 1 — one-cycle pulse when the outputs below update.
- `neg` — out, 1 — result negative.
- `err` — out, 1 — captured `sl` was illegal.
- `bcd_h`, `bcd_t`, `bcd_o` — out, 4 each — hundreds, tens and ones digits of the magnitude.
- `seg_s`, `seg_h`, `seg_t`, `seg_o` — out, 7 each — segment patterns, bit order g..a, active-high. `seg_s` is the sign digit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE, `start`=1:** capture `sl`, then form the 7-bit magnitude `mag`:
  - `sl`=`00`: `mag` = `c` (0..127).
  - `sl`=`11`: `c` is signed; if `c[6]`, `mag` = −`c` mod 128 and neg_r=1.
    - `c`=7'b1000000 gives `mag`=64.
  - Illegal `sl`: `mag`=0 and err_r=1.
  - Load `mag` into an 19-bit shift register {12 bits BCD, 7 bits binary}. BCD part = 0, `cnt`=0, go to SHIFT.
- **SHIFT:** each cycle:
  - Add 3 to every BCD nibble ≥5.
  - Shift the whole register left by 1 and increment `cnt`.
  - After the 7th shift (`cnt`=6 on entry) go to DONE.
- **DONE:**
  - Register `bcd_*`, `neg`, `err` and `seg_*` from the shift register and captured flags.
  - Pulse `done`, return to IDLE.
- **Segment rules:**
  - Digits 0–9 encode as 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
  - Leading-zero blanking (0000000): `seg_h` when `bcd_h`=0; `seg_t` when `bcd_h`=0 and `bcd_t`=0.
  - `seg_o` always shows its digit.
  - `seg_s`: 1111001 ('E') if err, else 1000000 ('-') if neg, else blank.
  - When err: `bcd_*`=0, `neg`=0, and `seg_h`/`seg_t`/`seg_o` are blank.
- **`start` handling:**
  - Ignored while not in IDLE; no queueing.
  - Held high continuously, it restarts a conversion on each IDLE cycle.
  - `c` and `sl` may change freely after acceptance.
- `busy` = (state ≠ IDLE).

## Timing
- **Reset:** `rst_n` low forces IDLE and clears all of the following; `done` does not fire for an aborted conversion. This applies at any time, including mid-conversion.
  - Outputs: `busy`, `done`, `neg`, `err`, `bcd_*`, and all `seg_*` (blank).
  - Internal: the shift register and `cnt`.
- **Latency:** `start` sampled high in IDLE at edge N gives:
  - `busy`=1 after edge N.
  - Shifts at edges N+1..N+7, DONE entered after N+7.
  - Outputs and `done`=1 after edge N+8.
  - `busy`=0 after edge N+8.
- **Throughput:** the next `start` can be accepted at edge N+9; one conversion per 9 cycles max.
- **Output stability:** result outputs hold their last values until the next DONE. They are unchanged during a conversion.

## Structure
- Package `jiajian_pkg` holds:
  - The state enum (IDLE/SHIFT/DONE).
  - `sl` code constants (`SL_ADD`=2'b00, `SL_SUB`=2'b11).
  - Segment constants: digit table, `SEG_BLANK`, `SEG_MINUS`, `SEG_E`.
  - Shift-count constant 7.
- Sub-module `seg7_dec`:
  - Combinational, 4-bit BCD plus blank input to 7-bit pattern.
  - Instantiated three times, for hundreds, tens and ones.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SHIFT (after edge N+3) → all outputs 0, `busy`=0, no `done`. The next `start` converts normally.
- **Unsigned maximum:** `sl`=00, `c`=126 →
  - `done` after edge N+8.
  - Digits 1/2/6, `neg`=0.
  - `seg_h`=0000110, `seg_t`=1011011, `seg_o`=1111101, `seg_s`=0000000.
- **Small negative:** `sl`=11, `c`=7'b1111011 →
  - `neg`=1, digits 0/0/5.
  - `seg_s`=1000000, `seg_h`=`seg_t`=0000000, `seg_o`=1101101.
- **Signed extremes:**
  - `sl`=11, `c`=7'b1000001 → `neg`=1, digits 0/6/3, `seg_t`=1111101, `seg_h` blank.
  - `sl`=11, `c`=7'b1000000 → `neg`=1, digits 0/6/4.
  - `sl`=11, `c`=0 → `neg`=0, `seg_o`=0111111, others blank.
- **Illegal select:** `sl`=10, `c`=55 →
  - `err`=1, `neg`=0, `bcd_*`=0.
  - `seg_s`=1111001, digit segments blank, same 8-cycle latency.
- **Start while busy:** pulse `start` with `c`=9 at N+2 during a conversion of `c`=100 (`sl`=00) →
  - A single `done` shows 1/0/0.
  - No second `done` until a new `start` in IDLE.

Source files
------------

// File: rtl/jiajian_pkg.sv
// Shared types and constants for the add/sub result display driver.
package jiajian_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [1:0] SL_ADD = 2'b00;
   localparam logic [1:0] SL_SUB = 2'b11;

   localparam int         NSHIFT   = 7;
   localparam logic [2:0] CNT_LAST = 3'(NSHIFT - 1);

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b1000000;
   localparam logic [6:0] SEG_E     = 7'b1111001;

   // Index n holds the g..a pattern for digit n.
   localparam logic [9:0][6:0] SEG_DIGIT = {
      7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
      7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/jiajian_disp_if.sv
// Result bus between the add/sub unit and the display driver.
interface jiajian_disp_if;
   logic [6:0] c;
   logic [1:0] sl;
   logic       start;
   logic       busy;
   logic       done;
   logic       neg;
   logic       err;
   logic [3:0] bcd_h;
   logic [3:0] bcd_t;
   logic [3:0] bcd_o;
   logic [6:0] seg_s;
   logic [6:0] seg_h;
   logic [6:0] seg_t;
   logic [6:0] seg_o;

   modport master (
      output c, sl, start,
      input  busy, done, neg, err,
      input  bcd_h, bcd_t, bcd_o,
      input  seg_s, seg_h, seg_t, seg_o
   );

   modport slave (
      input  c, sl, start,
      output busy, done, neg, err,
      output bcd_h, bcd_t, bcd_o,
      output seg_s, seg_h, seg_t, seg_o
   );
endinterface

// File: rtl/jiajian_disp_seg7_dec.sv
// BCD digit to seven-segment pattern, with forced blanking.
module seg7_dec
   import jiajian_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i && bcd_i <= 4'd9) begin
         seg_o = SEG_DIGIT[bcd_i];
      end
   end

endmodule

// File: rtl/jiajian_disp.sv
// Captures the adder result, converts it to sign + 3 BCD digits
// with a sequential double-dabble and drives static 7-seg patterns.
module jiajian_disp
   import jiajian_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   jiajian_disp_if.slave  bus
);

   state_e      state_q, state_d;
   logic [18:0] sr_q, sr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        err_q, err_d;

   logic        done_q, done_d;
   logic        nego_q, nego_d;
   logic        erro_q, erro_d;
   logic [3:0]  bh_q, bh_d;
   logic [3:0]  bt_q, bt_d;
   logic [3:0]  bo_q, bo_d;
   logic [6:0]  ss_q, ss_d;
   logic [6:0]  sh_q, sh_d;
   logic [6:0]  st_q, st_d;
   logic [6:0]  so_q, so_d;

   logic [6:0]  mag;
   logic        cap_neg;
   logic        cap_err;
   logic [18:0] adj;
   logic [3:0]  dig_h, dig_t, dig_o;
   logic [6:0]  seg_h_w, seg_t_w, seg_o_w;

   always_comb begin
      mag     = '0;
      cap_neg = 1'b0;
      cap_err = 1'b0;
      case (bus.sl)
         SL_ADD: mag = bus.c;
         SL_SUB: begin
            if (bus.c[6]) begin
               mag     = 7'(-bus.c);
               cap_neg = 1'b1;
            end else begin
               mag = bus.c;
            end
         end
         default: cap_err = 1'b1;
      endcase
   end

   assign adj = {add3(sr_q[18:15]),
                 add3(sr_q[14:11]),
                 add3(sr_q[10:7]),
                 sr_q[6:0]};

   assign dig_h = sr_q[18:15];
   assign dig_t = sr_q[14:11];
   assign dig_o = sr_q[10:7];

   // Tens are blanked only when hundreds are blank too.
   seg7_dec u_seg_h (
      .bcd_i   (dig_h),
      .blank_i (err_q || dig_h == 4'd0),
      .seg_o   (seg_h_w)
   );

   seg7_dec u_seg_t (
      .bcd_i   (dig_t),
      .blank_i (err_q || (dig_h == 4'd0 && dig_t == 4'd0)),
      .seg_o   (seg_t_w)
   );

   seg7_dec u_seg_o (
      .bcd_i   (dig_o),
      .blank_i (err_q),
      .seg_o   (seg_o_w)
   );

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      err_d   = err_q;
      done_d  = 1'b0;
      nego_d  = nego_q;
      erro_d  = erro_q;
      bh_d    = bh_q;
      bt_d    = bt_q;
      bo_d    = bo_q;
      ss_d    = ss_q;
      sh_d    = sh_q;
      st_d    = st_q;
      so_d    = so_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               neg_d   = cap_neg;
               err_d   = cap_err;
               sr_d    = {12'd0, mag};
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d  = {adj[17:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            nego_d  = neg_q && !err_q;
            erro_d  = err_q;
            bh_d    = err_q ? 4'd0 : dig_h;
            bt_d    = err_q ? 4'd0 : dig_t;
            bo_d    = err_q ? 4'd0 : dig_o;
            sh_d    = seg_h_w;
            st_d    = seg_t_w;
            so_d    = seg_o_w;
            if (err_q) begin
               ss_d = SEG_E;
            end else if (neg_q) begin
               ss_d = SEG_MINUS;
            end else begin
               ss_d = SEG_BLANK;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         nego_q  <= 1'b0;
         erro_q  <= 1'b0;
         bh_q    <= '0;
         bt_q    <= '0;
         bo_q    <= '0;
         ss_q    <= SEG_BLANK;
         sh_q    <= SEG_BLANK;
         st_q    <= SEG_BLANK;
         so_q    <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
         done_q  <= done_d;
         nego_q  <= nego_d;
         erro_q  <= erro_d;
         bh_q    <= bh_d;
         bt_q    <= bt_d;
         bo_q    <= bo_d;
         ss_q    <= ss_d;
         sh_q    <= sh_d;
         st_q    <= st_d;
         so_q    <= so_d;
      end
   end

   assign bus.busy  = (state_q != ST_IDLE);
   assign bus.done  = done_q;
   assign bus.neg   = nego_q;
   assign bus.err   = erro_q;
   assign bus.bcd_h = bh_q;
   assign bus.bcd_t = bt_q;
   assign bus.bcd_o = bo_q;
   assign bus.seg_s = ss_q;
   assign bus.seg_h = sh_q;
   assign bus.seg_t = st_q;
   assign bus.seg_o = so_q;

endmodule

// File: tb/tb_jiajian_disp.sv
// Directed bench for jiajian_disp: latency, digits, segments, reset.
module tb_jiajian_disp;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   logic [3:0] prev_o;
   logic [6:0] prev_s;

   jiajian_disp_if bus ();

   jiajian_disp dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy"},  bus.busy,  0);
      chk({tag, " done"},  bus.done,  0);
      chk({tag, " neg"},   bus.neg,   0);
      chk({tag, " err"},   bus.err,   0);
      chk({tag, " bcd_h"}, bus.bcd_h, 0);
      chk({tag, " bcd_t"}, bus.bcd_t, 0);
      chk({tag, " bcd_o"}, bus.bcd_o, 0);
      chk({tag, " seg_s"}, bus.seg_s, 0);
      chk({tag, " seg_h"}, bus.seg_h, 0);
      chk({tag, " seg_t"}, bus.seg_t, 0);
      chk({tag, " seg_o"}, bus.seg_o, 0);
   endtask

   task automatic chk_res(input string tag, input logic en, input logic ee,
                          input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] o, input logic [6:0] ss,
                          input logic [6:0] sh, input logic [6:0] st,
                          input logic [6:0] so);
      chk({tag, " neg"},   bus.neg,   en);
      chk({tag, " err"},   bus.err,   ee);
      chk({tag, " bcd_h"}, bus.bcd_h, h);
      chk({tag, " bcd_t"}, bus.bcd_t, t);
      chk({tag, " bcd_o"}, bus.bcd_o, o);
      chk({tag, " seg_s"}, bus.seg_s, ss);
      chk({tag, " seg_h"}, bus.seg_h, sh);
      chk({tag, " seg_t"}, bus.seg_t, st);
      chk({tag, " seg_o"}, bus.seg_o, so);
   endtask

   task automatic conv(input string tag, input logic [6:0] cv,
                       input logic [1:0] slv, input logic en,
                       input logic ee, input logic [3:0] h,
                       input logic [3:0] t, input logic [3:0] o,
                       input logic [6:0] ss, input logic [6:0] sh,
                       input logic [6:0] st, input logic [6:0] so);
      int early;
      early = 0;
      @(negedge clk);
      bus.c     = cv;
      bus.sl    = slv;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.c     = ~cv;
      bus.sl    = ~slv;
      chk({tag, " busy"}, bus.busy, 1);
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) early++;
         if (i == 4) begin
            chk({tag, " hold_o"}, bus.bcd_o, prev_o);
            chk({tag, " hold_s"}, bus.seg_s, prev_s);
         end
      end
      chk({tag, " early_done"}, early, 0);
      @(posedge clk);
      #1;
      chk({tag, " done"}, bus.done, 1);
      chk({tag, " idle"}, bus.busy, 0);
      chk_res(tag, en, ee, h, t, o, ss, sh, st, so);
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, bus.done, 0);
      prev_o = o;
      prev_s = ss;
   endtask

   initial begin
      int ndone;
      int first;
      n_chk     = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      bus.c     = '0;
      bus.sl    = '0;
      bus.start = 1'b0;
      prev_o    = '0;
      prev_s    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      conv("u126", 7'd126, 2'b00, 0, 0, 4'd1, 4'd2, 4'd6,
           7'b0000000, 7'b0000110, 7'b1011011, 7'b1111101);

      // Abort mid-conversion: after edge N+3.
      @(negedge clk);
      bus.c     = 7'd100;
      bus.sl    = 2'b00;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("abort no_done", ndone, 0);
      prev_o = '0;
      prev_s = '0;

      conv("u9", 7'd9, 2'b00, 0, 0, 4'd0, 4'd0, 4'd9,
           7'b0000000, 7'b0000000, 7'b0000000, 7'b1101111);
      conv("m5", 7'b1111011, 2'b11, 1, 0, 4'd0, 4'd0, 4'd5,
           7'b1000000, 7'b0000000, 7'b0000000, 7'b1101101);
      conv("m63", 7'b1000001, 2'b11, 1, 0, 4'd0, 4'd6, 4'd3,
           7'b1000000, 7'b0000000, 7'b1111101, 7'b1001111);
      conv("m64", 7'b1000000, 2'b11, 1, 0, 4'd0, 4'd6, 4'd4,
           7'b1000000, 7'b0000000, 7'b1111101, 7'b1100110);
      conv("s0", 7'd0, 2'b11, 0, 0, 4'd0, 4'd0, 4'd0,
           7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);
      conv("ill10", 7'd55, 2'b10, 0, 1, 4'd0, 4'd0, 4'd0,
           7'b1111001, 7'b0000000, 7'b0000000, 7'b0000000);
      conv("p63", 7'd63, 2'b11, 0, 0, 4'd0, 4'd6, 4'd3,
           7'b0000000, 7'b0000000, 7'b1111101, 7'b1001111);
      conv("ill01", 7'b1100100, 2'b01, 0, 1, 4'd0, 4'd0, 4'd0,
           7'b1111001, 7'b0000000, 7'b0000000, 7'b0000000);
      conv("u123", 7'b1111011, 2'b00, 0, 0, 4'd1, 4'd2, 4'd3,
           7'b0000000, 7'b0000110, 7'b1011011, 7'b1001111);

      // Second start at N+2 must be dropped.
      @(negedge clk);
      bus.c     = 7'd100;
      bus.sl    = 2'b00;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.c     = 7'd9;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ndone = 0;
      first = 0;
      for (int e = 3; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            if (first == 0) first = e;
         end
         if (e == 8) begin
            chk_res("busy100", 0, 0, 4'd1, 4'd0, 4'd0,
                    7'b0000000, 7'b0000110, 7'b0111111, 7'b0111111);
         end
      end
      chk("busy ndone", ndone, 1);
      chk("busy edge", first, 8);
      chk("busy final_o", bus.bcd_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
